// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation/state encodings and flag layout for the multiply/divide unit
package muldiv_pkg;
    typedef enum logic [1:0] {MULU = 2'd0, MULS = 2'd1, DIVU = 2'd2, DIVS = 2'd3} md_op;
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} md_state;
    localparam int FLAG_S = 7;
    localparam int FLAG_Z = 6;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 0;
    function automatic logic [7:0] make_flag(input logic s, input logic z, input logic v, input logic c);
        logic [7:0] f;
        f = '0;
        f[FLAG_S] = s;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction
endpackage

// File: rtl/muldiv_sign.sv
// muldiv_sign: conditional two's-complement negate; yields |val| when neg is the operand sign
module muldiv_sign #(
    parameter int W = 16
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = neg ? -val : val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULU/MULS/DIVU/DIVS unit (shift-add multiply, restoring divide)
// Define MULDIV_EARLY_TERM_EN to leave multiply CALC as soon as the multiplier is exhausted.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [7:0]       flag
);
    localparam int CW = $clog2(WIDTH);
    md_state            state;
    md_op               op_r;
    logic [WIDTH-1:0]   a_r, b_r, a_mag, b_mag, mplier, rem, dq, q_fix, r_fix, rem_sub, res_hi, res_lo;
    logic [2*WIDTH-1:0] acc, mcand, p_fix;
    logic [WIDTH:0]     rem_sh;
    logic [CW-1:0]      cnt;
    logic               is_mul, is_signed, sa, sb, rem_ge, calc_last, div_ovf, flag_v;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign is_mul    = op_r == MULU || op_r == MULS;
    assign is_signed = op_r == MULS || op_r == DIVS;
    assign sa        = is_signed & a_r[WIDTH-1];
    assign sb        = is_signed & b_r[WIDTH-1];
    muldiv_sign #(.W(WIDTH))   u_abs_a (.val(a_r), .neg(sa), .res(a_mag));
    muldiv_sign #(.W(WIDTH))   u_abs_b (.val(b_r), .neg(sb), .res(b_mag));
    muldiv_sign #(.W(2*WIDTH)) u_fix_p (.val(acc), .neg(sa ^ sb), .res(p_fix));
    muldiv_sign #(.W(WIDTH))   u_fix_q (.val(dq),  .neg(sa ^ sb), .res(q_fix));
    muldiv_sign #(.W(WIDTH))   u_fix_r (.val(rem), .neg(sa),      .res(r_fix));
    // The divisor magnitude stays valid from b_r, so the subtractor needs no extra register.
    assign rem_sh  = {rem, dq[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, b_mag};
    assign rem_sub = rem_sh[WIDTH-1:0] - b_mag;
`ifdef MULDIV_EARLY_TERM_EN
    assign calc_last = cnt == '0 || (is_mul && mplier[WIDTH-1:1] == '0);
`else
    assign calc_last = cnt == '0;
`endif
    assign div_ovf = op_r == DIVS && a_r == {1'b1, {(WIDTH-1){1'b0}}} && &b_r;
    assign res_hi  = is_mul ? p_fix[2*WIDTH-1:WIDTH] : r_fix;
    assign res_lo  = is_mul ? p_fix[WIDTH-1:0] : q_fix;
    assign flag_v  = !is_mul ? div_ovf :
                     op_r == MULS ? res_hi != {WIDTH{res_lo[WIDTH-1]}} : res_hi != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_r      <= MULU;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            dq        <= '0;
            cnt       <= '0;
            result_hi <= '0;
            result_lo <= '0;
            flag      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r  <= md_op'(op);
                    a_r   <= a;
                    b_r   <= b;
                    state <= PREP;
                end
                PREP: if (!is_mul && b_r == '0) begin
                    result_lo <= '1;
                    result_hi <= a_r;
                    flag      <= make_flag(1'b1, 1'b0, 1'b1, 1'b0);
                    state     <= DONE;
                end else begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, a_mag};
                    mplier <= b_mag;
                    rem    <= '0;
                    dq     <= a_mag;
                    cnt    <= CW'(WIDTH-1);
                    state  <= CALC;
                end
                CALC: begin
                    if (is_mul) begin
                        acc    <= mplier[0] ? acc + mcand : acc;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        rem <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                        dq  <= {dq[WIDTH-2:0], rem_ge};
                    end
                    cnt   <= cnt - CW'(1);
                    state <= calc_last ? FIX : CALC;
                end
                FIX: begin
                    result_hi <= res_hi;
                    result_lo <= res_lo;
                    flag      <= make_flag(is_mul ? res_hi[WIDTH-1] : res_lo[WIDTH-1],
                                           is_mul ? p_fix == '0 : q_fix == '0,
                                           flag_v,
                                           is_mul ? flag_v : r_fix != '0);
                    state     <= DONE;
                end
                DONE: state <= out_ready ? IDLE : DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    localparam int W = 16;
    logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [1:0]   op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic         in_ready, out_valid;
    logic [W-1:0] result_hi, result_lo;
    logic [7:0]   flag;
    int           n_chk = 0, n_fail = 0;
    logic [15:0]  eh, el;
    logic [7:0]   ef;
    int           lat, n, seen;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result_hi(result_hi), .result_lo(result_lo),
        .flag(flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] hi, output logic [15:0] lo,
                                  output logic [7:0] f, output int lt);
        longint      p, q, r;
        logic [31:0] pw;
        logic [15:0] m;
        logic        s, z, v, c;
        int          k;
        lt = W + 3;
        if (o < 2) begin
            p  = (o == 0) ? longint'(x) * longint'(y) : longint'($signed(x)) * longint'($signed(y));
            pw = p[31:0];
            hi = pw[31:16];
            lo = pw[15:0];
            v  = (o == 0) ? (p >= 65536) : (p < -32768 || p > 32767);
            c  = v;
            z  = p == 0;
            s  = hi[15];
`ifdef MULDIV_EARLY_TERM_EN
            m = (o == 1 && y[15]) ? -y : y;
            k = 0;
            while (m != 0) begin
                k++;
                m = m >> 1;
            end
            lt = (k == 0 ? 1 : k) + 3;
`endif
        end else if (y == 0) begin
            hi = x; lo = 16'hFFFF; v = 1; c = 0; z = 0; s = 1; lt = 2;
        end else if (o == 3 && x == 16'h8000 && y == 16'hFFFF) begin
            hi = 0; lo = 16'h8000; v = 1; c = 0; z = 0; s = 1;
        end else begin
            if (o == 2) begin
                q = longint'(x) / longint'(y);
                r = longint'(x) % longint'(y);
            end else begin
                q = longint'($signed(x)) / longint'($signed(y));
                r = longint'($signed(x)) % longint'($signed(y));
            end
            lo = q[15:0];
            hi = r[15:0];
            v  = 0;
            c  = r != 0;
            z  = q == 0;
            s  = lo[15];
        end
        f = {s, z, 3'b000, v, 1'b0, c};
    endfunction

    task automatic start(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        check("idle_ready", {31'b0, in_ready}, 1);
        op = o; a = x; b = y; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk);
            cnt++;
            #1;
        end
        if (!out_valid) check("timeout", 0, 1);
    endtask

    task automatic run(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] xh, xl;
        logic [7:0]  xf;
        int          xl_t, cyc;
        model(o, x, y, xh, xl, xf, xl_t);
        start(o, x, y);
        wait_valid(cyc);
        if (out_valid) begin
            check("latency", cyc + 1, xl_t);
            check("result_hi", result_hi, xh);
            check("result_lo", result_lo, xl);
            check("flag", flag, xf);
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        check("release_valid", {31'b0, out_valid}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check("rst_ready", {31'b0, in_ready}, 1);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_hi", result_hi, 0);
        check("rst_lo", result_lo, 0);
        check("rst_flag", flag, 0);
        run(2'd0, 16'h1234, 16'h0056);
        run(2'd1, 16'hFFFE, 16'h0003);
        run(2'd2, 16'h5678, 16'h0012);
        run(2'd3, 16'hFFF9, 16'h0002);
        run(2'd3, 16'h8000, 16'hFFFF);
        run(2'd2, 16'h1234, 16'h0000);
        run(2'd3, 16'h8001, 16'h0000);
        run(2'd0, 16'h0005, 16'h0003);
        run(2'd1, 16'h8000, 16'h8000);
        run(2'd0, 16'hFFFF, 16'hFFFF);
        run(2'd1, 16'h0000, 16'h7FFF);
        run(2'd2, 16'h0003, 16'h0007);
        // result must hold in DONE while the consumer stalls
        model(2'd1, 16'hBEEF, 16'h0123, eh, el, ef, lat);
        start(2'd1, 16'hBEEF, 16'h0123);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; op = 2'd2; a = 16'($urandom); b = 16'd1;
            @(posedge clk);
            #1;
            check("hold_valid", {31'b0, out_valid}, 1);
            check("hold_ready", {31'b0, in_ready}, 0);
            check("hold_hi", result_hi, eh);
            check("hold_lo", result_lo, el);
            check("hold_flag", flag, ef);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        check("after_hold_ready", {31'b0, in_ready}, 1);
        check("after_hold_valid", {31'b0, out_valid}, 0);
        // reset in the middle of CALC drops the operation
        start(2'd0, 16'h7777, 16'h3333);
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        check("midrst_ready", {31'b0, in_ready}, 1);
        check("midrst_valid", {31'b0, out_valid}, 0);
        check("midrst_lo", result_lo, 0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1 seen += out_valid;
        end
        check("midrst_no_pulse", seen, 0);
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [15:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 4) == 0) rb = 16'($urandom_range(1, 15));
            run(ro, ra, rb);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
